// File: rtl/bbj64_seq.sv
// BitBitJump-64 instruction sequencer running against a single-port 64-bit-word memory.
// Each instruction does three fetches, one source-bit read and a read-modify-write of the destination word, then jumps.
module bbj64_seq #(
    parameter logic [63:0] RESET_IP = 64'h00C0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             mem_req,
    output logic             mem_we,
    output logic [57:0]      mem_addr,
    output logic [63:0]      mem_wdata,
    input  logic [63:0]      mem_rdata,
    input  logic             mem_ack,
    output logic [63:0]      ip,
    output logic [CNT_W-1:0] retired,
    output logic             busy,
    output logic             halted
);

    typedef enum logic [2:0] {
        IDLE,
        F_DST,
        F_SRC,
        F_JMP,
        RD_SRC,
        RD_DST,
        WR_DST
    } state_t;

    state_t      state;
    logic [63:0] dst;
    logic [63:0] src;
    logic [63:0] jmp;
    logic        src_bit;
    logic [57:0] iw;
    logic        ack;
    logic [63:0] dst_mask;

    assign iw       = ip[63:6];
    assign ack      = mem_req & mem_ack;
    assign dst_mask = 64'd1 << dst[5:0];
    assign busy     = (state != IDLE);

    // The next access's address is loaded on the same edge as the current ack, so zero-wait memory sees req back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ip        <= RESET_IP;
            retired   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
            dst       <= '0;
            src       <= '0;
            jmp       <= '0;
            src_bit   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run && !halted) begin
                        state    <= F_DST;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= iw;
                    end
                end
                F_DST: begin
                    if (ack) begin
                        dst      <= mem_rdata;
                        mem_addr <= iw + 58'd1;
                        state    <= F_SRC;
                    end
                end
                F_SRC: begin
                    if (ack) begin
                        src      <= mem_rdata;
                        mem_addr <= iw + 58'd2;
                        state    <= F_JMP;
                    end
                end
                F_JMP: begin
                    if (ack) begin
                        jmp      <= mem_rdata;
                        mem_addr <= src[63:6];
                        state    <= RD_SRC;
                    end
                end
                RD_SRC: begin
                    if (ack) begin
                        src_bit  <= mem_rdata[src[5:0]];
                        mem_addr <= dst[63:6];
                        state    <= RD_DST;
                    end
                end
                RD_DST: begin
                    // Merge the source bit into the freshly read word; the write happens even if nothing changes.
                    if (ack) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= (mem_rdata & ~dst_mask) | (src_bit ? dst_mask : 64'd0);
                        state     <= WR_DST;
                    end
                end
                WR_DST: begin
                    if (ack) begin
                        ip      <= jmp;
                        retired <= retired + CNT_W'(1);
                        halted  <= (jmp == ip);
                        mem_we  <= 1'b0;
                        if (run && (jmp != ip)) begin
                            state    <= F_DST;
                            mem_addr <= jmp[63:6];
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bbj64_seq.sv
// Testbench for bbj64_seq: behavioural memory with random wait states plus an instruction-level reference model.
// Expected memory accesses are queued by the model and checked by the memory responder as the DUT issues them.
module tb_bbj64_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        mem_req;
    logic        mem_we;
    logic [57:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [63:0] ip;
    logic [31:0] retired;
    logic        busy;
    logic        halted;

    always #5 clk = ~clk;

    bbj64_seq #(
        .RESET_IP(64'h00C0),
        .CNT_W   (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .ip       (ip),
        .retired  (retired),
        .busy     (busy),
        .halted   (halted)
    );

    typedef struct packed {
        logic        we;
        logic [57:0] addr;
        logic [63:0] wdata;
    } acc_t;

    acc_t        exp_q[$];
    logic [63:0] dmem[logic [57:0]];
    logic [63:0] rmem[logic [57:0]];
    int          total = 0;
    int          bad = 0;
    int          wait_mode = 0;
    int          req_cycles = 0;
    logic [63:0] m_ip;
    logic [31:0] m_ret;
    logic        m_halt;

    function automatic logic [63:0] rd_d(input logic [57:0] a);
        if (dmem.exists(a)) return dmem[a];
        return 64'd0;
    endfunction

    function automatic logic [63:0] rd_r(input logic [57:0] a);
        if (rmem.exists(a)) return rmem[a];
        return 64'd0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic poke(input logic [57:0] a, input logic [63:0] v);
        dmem[a] = v;
        rmem[a] = v;
    endtask

    // One instruction executed straight from the rules on the model memory; queues the six accesses it implies.
    task automatic model_step();
        logic [57:0] w;
        logic [63:0] d, s, j, sw, ow, nw;
        w  = m_ip[63:6];
        d  = rd_r(w);
        s  = rd_r(w + 58'd1);
        j  = rd_r(w + 58'd2);
        sw = rd_r(s[63:6]);
        ow = rd_r(d[63:6]);
        nw = ow;
        nw[d[5:0]] = sw[s[5:0]];
        exp_q.push_back('{1'b0, w, 64'd0});
        exp_q.push_back('{1'b0, w + 58'd1, 64'd0});
        exp_q.push_back('{1'b0, w + 58'd2, 64'd0});
        exp_q.push_back('{1'b0, s[63:6], 64'd0});
        exp_q.push_back('{1'b0, d[63:6], 64'd0});
        exp_q.push_back('{1'b1, d[63:6], nw});
        rmem[d[63:6]] = nw;
        m_halt = (j == m_ip);
        m_ip   = j;
        m_ret  = m_ret + 32'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ip   = 64'h00C0;
        m_ret  = 32'd0;
        m_halt = 1'b0;
        exp_q.delete();
    endtask

    task automatic fill_random();
        logic [63:0] v;
        dmem.delete();
        rmem.delete();
        for (int i = 0; i < 64; i++) begin
            v = {52'd0, 12'($urandom_range(0, 4095))};
            poke(58'(i), v);
        end
    endtask

    // Runs up to n instructions with run held high, dropping run while the last one is in flight.
    task automatic applyStimulus(input int n);
        int          k;
        int          guard;
        logic [31:0] start;
        req_cycles = 0;
        if (m_halt) begin
            @(negedge clk);
            run = 1'b1;
            repeat (8) @(negedge clk);
            checkOutput("halt_req_cycles", 64'(req_cycles), 64'd0);
            checkOutput("halt_busy", {63'd0, busy}, 64'd0);
            checkOutput("halt_sticky", {63'd0, halted}, 64'd1);
            run = 1'b0;
            return;
        end
        start = m_ret;
        k = 0;
        while (k < n && !m_halt) begin
            model_step();
            k++;
        end
        @(negedge clk);
        run = 1'b1;
        guard = 0;
        while (!(!busy && retired == start + 32'(k)) && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (run && busy && retired == start + 32'(k - 1)) run = 1'b0;
        end
        run = 1'b0;
        if (guard >= 4000) checkOutput("done_timeout", 64'(guard), 64'd0);
        checkOutput("ip", ip, m_ip);
        checkOutput("retired", {32'd0, retired}, {32'd0, m_ret});
        checkOutput("halted", {63'd0, halted}, {63'd0, m_halt});
        checkOutput("exp_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Memory responder and access monitor: pops one expectation per new request, checks hold stability during waits.
    logic pending = 1'b0;
    acc_t held;
    acc_t e;
    int   wcnt = 0;

    always @(negedge clk) begin
        if (mem_req) begin
            req_cycles++;
            if (!pending) begin
                pending = 1'b1;
                held = '{mem_we, mem_addr, mem_wdata};
                wcnt = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_access", {6'd0, mem_addr}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("acc_we", {63'd0, mem_we}, {63'd0, e.we});
                    checkOutput("acc_addr", {6'd0, mem_addr}, {6'd0, e.addr});
                    if (e.we) checkOutput("acc_wdata", mem_wdata, e.wdata);
                end
            end else begin
                checkOutput("hold_stable", {63'd0, ({mem_we, mem_addr, mem_wdata} == held)}, 64'd1);
            end
            if (wcnt == 0) begin
                mem_ack = 1'b1;
                if (mem_we) dmem[mem_addr] = mem_wdata;
                else mem_rdata = rd_d(mem_addr);
                pending = 1'b0;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = {$urandom, $urandom};
                wcnt--;
            end
        end else begin
            pending = 1'b0;
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = {$urandom, $urandom};
        end
    end

    initial begin
        int g;
        rst = 1'b1;
        run = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 64'd0;
        m_ip = 64'h00C0;
        m_ret = 32'd0;
        m_halt = 1'b0;

        do_reset();
        checkOutput("rst_ip", ip, 64'h00C0);
        checkOutput("rst_retired", {32'd0, retired}, 64'd0);
        checkOutput("rst_req", {63'd0, mem_req}, 64'd0);
        checkOutput("rst_we", {63'd0, mem_we}, 64'd0);
        checkOutput("rst_addr", {6'd0, mem_addr}, 64'd0);
        checkOutput("rst_wdata", mem_wdata, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_halted", {63'd0, halted}, 64'd0);

        // Directed program, zero-wait memory.
        poke(58'd3, 64'h1005);
        poke(58'd4, 64'h2003);
        poke(58'd5, 64'h0100);
        poke(58'h80, 64'h8);
        poke(58'h40, 64'h0);
        wait_mode = 0;
        applyStimulus(1);
        checkOutput("zw_cycles", 64'(req_cycles), 64'd6);
        checkOutput("zw_word40", rd_d(58'h40), 64'h20);
        checkOutput("zw_ip", ip, 64'h100);

        // Same program with three wait cycles per access.
        do_reset();
        poke(58'h40, 64'h0);
        wait_mode = 3;
        applyStimulus(1);
        checkOutput("ws_cycles", 64'(req_cycles), 64'd24);
        checkOutput("ws_word40", rd_d(58'h40), 64'h20);
        checkOutput("ws_ip", ip, 64'h100);

        // Self-jump halts and stays halted with run high.
        do_reset();
        wait_mode = 0;
        poke(58'd5, 64'h00C0);
        applyStimulus(1);
        checkOutput("selfjump_halted", {63'd0, halted}, 64'd1);
        applyStimulus(1);

        // Jump to the top word so the operand fetches wrap to words 0 and 1.
        do_reset();
        wait_mode = -1;
        poke(58'd3, 64'h1000);
        poke(58'd4, 64'h2001);
        poke(58'd5, 64'hFFFF_FFFF_FFFF_FFC0);
        poke(58'h3FF_FFFF_FFFF_FFFF, 64'h1000);
        poke(58'd0, 64'h2002);
        poke(58'd1, 64'h0140);
        applyStimulus(2);
        checkOutput("wrap_ip", ip, 64'h140);

        // Random self-modifying programs in a 64-word region.
        for (int r = 0; r < 15; r++) begin
            if (m_halt || (r % 5) == 0) begin
                do_reset();
                fill_random();
            end
            wait_mode = ($urandom_range(0, 1) == 0) ? -1 : 0;
            applyStimulus(int'($urandom_range(1, 5)));
        end

        // Reset arriving together with the write ack.
        do_reset();
        fill_random();
        poke(58'd3, 64'h1005);
        poke(58'd4, 64'h2003);
        poke(58'd5, 64'h0100);
        wait_mode = 0;
        model_step();
        @(negedge clk);
        run = 1'b1;
        g = 0;
        while (!(mem_req && mem_we) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) checkOutput("wr_timeout", 64'(g), 64'd0);
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        checkOutput("rstack_req", {63'd0, mem_req}, 64'd0);
        checkOutput("rstack_ip", ip, 64'h00C0);
        checkOutput("rstack_retired", {32'd0, retired}, 64'd0);
        checkOutput("rstack_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
